// File: rtl/auto_drive_scheduler_if.sv
// Handshake bundle between the autonomous driving scheduler and its surroundings:
// enable and detector inputs, auto_turning busy flag, and the drive/trigger/status outputs.
interface auto_drive_scheduler_if;
    logic       enable;
    logic       detector_front;
    logic       detector_left;
    logic       detector_right;
    logic       is_turning;
    logic       move_forward;
    logic       trigger_turn_left;
    logic       trigger_turn_right;
    logic       trigger_turn_back;
    logic       busy;
    logic [2:0] state;
    logic [7:0] turn_count;

    // Environment side: drives enable, detectors and is_turning, observes the scheduler.
    modport master (
        output enable, detector_front, detector_left, detector_right, is_turning,
        input  move_forward, trigger_turn_left, trigger_turn_right, trigger_turn_back,
        input  busy, state, turn_count
    );

    // Scheduler side.
    modport slave (
        input  enable, detector_front, detector_left, detector_right, is_turning,
        output move_forward, trigger_turn_left, trigger_turn_right, trigger_turn_back,
        output busy, state, turn_count
    );
endinterface

// File: rtl/auto_drive_scheduler.sv
// Autonomous drive sequencer sitting above auto_turning: cruises forward, debounces the
// front detector, settles, picks a turn direction from the side detectors, fires a
// one-cycle trigger, retries until auto_turning acknowledges, then drives straight out
// of the turn before re-arming. All outputs are registered from the next-state values.
module auto_drive_scheduler #(
    parameter int DEBOUNCE     = 5,
    parameter int SETTLE_TICKS = 50,
    parameter int ACK_TIMEOUT  = 8,
    parameter int EXIT_TICKS   = 250
) (
    input  logic                         clk,
    input  logic                         rst_n,
    auto_drive_scheduler_if.slave        bus
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CRUISE    = 3'd1,
        S_SETTLE    = 3'd2,
        S_FIRE      = 3'd3,
        S_WAIT_ACK  = 3'd4,
        S_WAIT_DONE = 3'd5,
        S_EXIT      = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        DIR_LEFT  = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_BACK  = 2'd2
    } dir_e;

    // Terminal counts: a counter holding value N-1 marks the last cycle of an N-cycle phase.
    localparam logic [15:0] DEB_LAST    = 16'(DEBOUNCE - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_TICKS - 1);
    localparam logic [15:0] ACK_LAST    = 16'(ACK_TIMEOUT - 1);
    localparam logic [15:0] EXIT_LAST   = 16'(EXIT_TICKS - 1);

    state_e      state_q, state_d;
    dir_e        dir_q, dir_d;
    logic [15:0] deb_q, deb_d;
    logic [15:0] tick_q, tick_d;
    logic [7:0]  turn_count_q, turn_count_d;
    logic        move_forward_q, move_forward_d;
    logic        trig_left_q, trig_left_d;
    logic        trig_right_q, trig_right_d;
    logic        trig_back_q, trig_back_d;
    logic        busy_q, busy_d;

    // Next-state, counters, direction latch and completed-turn count.
    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        deb_d        = deb_q;
        tick_d       = tick_q;
        turn_count_d = turn_count_q;

        if (!bus.enable) begin
            // Leaving auto mode abandons any turn in progress without counting it.
            state_d = S_IDLE;
            deb_d   = '0;
            tick_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_CRUISE;
                    deb_d   = '0;
                    tick_d  = '0;
                end
                S_CRUISE: begin
                    if (bus.detector_front) begin
                        if (deb_q >= DEB_LAST) begin
                            state_d = S_SETTLE;
                            deb_d   = '0;
                            tick_d  = '0;
                        end else begin
                            deb_d = deb_q + 16'd1;
                        end
                    end else begin
                        deb_d = '0;
                    end
                end
                S_SETTLE: begin
                    if (tick_q >= SETTLE_LAST) begin
                        state_d = S_FIRE;
                        tick_d  = '0;
                        // Left has priority; both sides blocked means turn back.
                        if (!bus.detector_left) begin
                            dir_d = DIR_LEFT;
                        end else if (!bus.detector_right) begin
                            dir_d = DIR_RIGHT;
                        end else begin
                            dir_d = DIR_BACK;
                        end
                    end else begin
                        tick_d = tick_q + 16'd1;
                    end
                end
                S_FIRE: begin
                    state_d = S_WAIT_ACK;
                    tick_d  = '0;
                end
                S_WAIT_ACK: begin
                    // An acknowledge arriving on the timeout cycle wins over a re-fire.
                    if (bus.is_turning) begin
                        state_d = S_WAIT_DONE;
                        tick_d  = '0;
                    end else if (tick_q >= ACK_LAST) begin
                        state_d = S_FIRE;
                        tick_d  = '0;
                    end else begin
                        tick_d = tick_q + 16'd1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!bus.is_turning) begin
                        state_d      = S_EXIT;
                        tick_d       = '0;
                        turn_count_d = turn_count_q + 8'd1;
                    end
                end
                S_EXIT: begin
                    // Detectors are ignored here; CRUISE restarts debouncing from zero.
                    if (tick_q >= EXIT_LAST) begin
                        state_d = S_CRUISE;
                        tick_d  = '0;
                        deb_d   = '0;
                    end else begin
                        tick_d = tick_q + 16'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    deb_d   = '0;
                    tick_d  = '0;
                end
            endcase
        end
    end

    // Registered outputs are decoded from the next state so they line up with state_q.
    always_comb begin
        move_forward_d = (state_d == S_CRUISE) || (state_d == S_EXIT);
        trig_left_d    = (state_d == S_FIRE) && (dir_d == DIR_LEFT);
        trig_right_d   = (state_d == S_FIRE) && (dir_d == DIR_RIGHT);
        trig_back_d    = (state_d == S_FIRE) && (dir_d == DIR_BACK);
        busy_d         = (state_d == S_SETTLE) || (state_d == S_FIRE) ||
                         (state_d == S_WAIT_ACK) || (state_d == S_WAIT_DONE);
    end

    // State, counters and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            dir_q          <= DIR_LEFT;
            deb_q          <= '0;
            tick_q         <= '0;
            turn_count_q   <= '0;
            move_forward_q <= 1'b0;
            trig_left_q    <= 1'b0;
            trig_right_q   <= 1'b0;
            trig_back_q    <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            dir_q          <= dir_d;
            deb_q          <= deb_d;
            tick_q         <= tick_d;
            turn_count_q   <= turn_count_d;
            move_forward_q <= move_forward_d;
            trig_left_q    <= trig_left_d;
            trig_right_q   <= trig_right_d;
            trig_back_q    <= trig_back_d;
            busy_q         <= busy_d;
        end
    end

    assign bus.state              = state_q;
    assign bus.turn_count         = turn_count_q;
    assign bus.move_forward       = move_forward_q;
    assign bus.trigger_turn_left  = trig_left_q;
    assign bus.trigger_turn_right = trig_right_q;
    assign bus.trigger_turn_back  = trig_back_q;
    assign bus.busy               = busy_q;

endmodule

// File: tb/tb_auto_drive_scheduler.sv
// Self-checking bench for auto_drive_scheduler: directed scenarios plus randomized turns
// checked against timing and direction rules computed inside the bench.
module tb_auto_drive_scheduler;

    localparam int DEB = 5;
    localparam int SET = 20;
    localparam int ACK = 8;
    localparam int EXT = 40;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    auto_drive_scheduler_if bus ();

    auto_drive_scheduler #(
        .DEBOUNCE    (DEB),
        .SETTLE_TICKS(SET),
        .ACK_TIMEOUT (ACK),
        .EXIT_TICKS  (EXT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int model_count = 0;

    // Expected trigger vector {back, right, left} from the side detectors.
    function automatic logic [2:0] exp_trig(input logic l, input logic r);
        if (!l) return 3'b001;
        if (!r) return 3'b010;
        return 3'b100;
    endfunction

    function automatic logic [2:0] trig_now();
        return {bus.trigger_turn_back, bus.trigger_turn_right, bus.trigger_turn_left};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Tick until the state output equals s; n = ticks taken, -1 if the budget expired.
    task automatic wait_state(input logic [2:0] s, input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (bus.state == s) begin
                n = i;
                break;
            end
        end
    endtask

    // From a just-observed FIRE: acknowledge, complete the turn and ride out EXIT.
    task automatic finish_turn(output int n_exit);
        tick();
        bus.is_turning = 1'b1;
        tick();
        bus.is_turning = 1'b0;
        tick();
        model_count = (model_count + 1) % 256;
        wait_state(3'd1, EXT + 5, n_exit);
    endtask

    task automatic test_reset();
        bus.enable = 1'b1;
        bus.detector_front = 1'b0;
        bus.detector_left = 1'b0;
        bus.detector_right = 1'b0;
        bus.is_turning = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if (bus.state !== 3'd0) begin
            n_fail++; $display("FAIL reset_state: got %0d expected 0", bus.state);
        end
        n_checks++;
        if ({bus.move_forward, trig_now(), bus.busy} !== 5'b0) begin
            n_fail++; $display("FAIL reset_outputs: got %b expected 00000",
                                {bus.move_forward, trig_now(), bus.busy});
        end
        n_checks++;
        if (bus.turn_count !== 8'd0) begin
            n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.turn_count);
        end
        rst_n = 1'b1;
        model_count = 0;
        tick();
        n_checks++;
        if ({bus.state, bus.move_forward, bus.busy} !== {3'd1, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL reset_to_cruise: got state %0d mf %b busy %b expected 1 1 0",
                                bus.state, bus.move_forward, bus.busy);
        end
    endtask

    task automatic test_debounce();
        int bad;
        int n;
        bad = 0;
        bus.detector_front = 1'b1;
        for (int i = 0; i < DEB - 1; i++) begin
            tick();
            if (bus.state !== 3'd1) bad++;
        end
        bus.detector_front = 1'b0;
        tick();
        if (bus.state !== 3'd1) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL short_front_stays_cruise: got %0d bad cycles expected 0", bad);
        end
        bus.detector_left = 1'b0;
        bus.detector_right = 1'b0;
        bus.detector_front = 1'b1;
        bad = 0;
        for (int i = 0; i < DEB - 1; i++) begin
            tick();
            if (bus.state !== 3'd1) bad++;
        end
        tick();
        bus.detector_front = 1'b0;
        n_checks++;
        if ({bus.state, bus.move_forward, bus.busy} !== {3'd2, 1'b0, 1'b1} || bad != 0) begin
            n_fail++; $display("FAIL debounce_to_settle: got state %0d mf %b busy %b early %0d expected 2 0 1 0",
                                bus.state, bus.move_forward, bus.busy, bad);
        end
        bad = 0;
        for (int i = 0; i < SET - 1; i++) begin
            tick();
            if ({bus.state, trig_now(), bus.move_forward} !== {3'd2, 3'b000, 1'b0}) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL settle_quiet: got %0d bad cycles expected 0", bad);
        end
        tick();
        n_checks++;
        if ({bus.state, trig_now()} !== {3'd3, exp_trig(1'b0, 1'b0)}) begin
            n_fail++; $display("FAIL settle_latency_left: got state %0d trig %b expected 3 %b",
                                bus.state, trig_now(), exp_trig(1'b0, 1'b0));
        end
        finish_turn(n);
        n_checks++;
        if (bus.turn_count !== 8'(model_count) || n != EXT) begin
            n_fail++; $display("FAIL debounce_turn_done: got count %0d exit %0d expected %0d %0d",
                                bus.turn_count, n, model_count, EXT);
        end
    endtask

    task automatic test_directions();
        logic [1:0] lr_tab [3];
        int n;
        lr_tab[0] = 2'b10;
        lr_tab[1] = 2'b11;
        lr_tab[2] = 2'b01;
        for (int k = 0; k < 3; k++) begin
            bus.detector_left = lr_tab[k][1];
            bus.detector_right = lr_tab[k][0];
            bus.detector_front = 1'b1;
            wait_state(3'd3, DEB + SET + 10, n);
            bus.detector_front = 1'b0;
            n_checks++;
            if (n != DEB + SET || trig_now() !== exp_trig(lr_tab[k][1], lr_tab[k][0])) begin
                n_fail++; $display("FAIL direction_%0d: got latency %0d trig %b expected %0d %b",
                                    k, n, trig_now(), DEB + SET, exp_trig(lr_tab[k][1], lr_tab[k][0]));
            end
            tick();
            n_checks++;
            if ({bus.state, trig_now()} !== {3'd4, 3'b000}) begin
                n_fail++; $display("FAIL direction_one_cycle_%0d: got state %0d trig %b expected 4 000",
                                    k, bus.state, trig_now());
            end
            bus.is_turning = 1'b1;
            tick();
            bus.is_turning = 1'b0;
            tick();
            model_count = (model_count + 1) % 256;
            wait_state(3'd1, EXT + 5, n);
            n_checks++;
            if (bus.turn_count !== 8'(model_count)) begin
                n_fail++; $display("FAIL direction_count_%0d: got %0d expected %0d",
                                    k, bus.turn_count, model_count);
            end
        end
    endtask

    task automatic test_ack_retry();
        int bad;
        int n;
        bus.detector_left = 1'b1;
        bus.detector_right = 1'b0;
        bus.detector_front = 1'b1;
        bus.is_turning = 1'b0;
        wait_state(3'd3, DEB + SET + 10, n);
        bus.detector_front = 1'b0;
        for (int r = 1; r <= 3; r++) begin
            bad = 0;
            for (int i = 0; i < ACK; i++) begin
                tick();
                if ({bus.state, trig_now()} !== {3'd4, 3'b000}) bad++;
            end
            tick();
            n_checks++;
            if ({bus.state, trig_now()} !== {3'd3, 3'b010} || bad != 0) begin
                n_fail++; $display("FAIL refire_%0d: got state %0d trig %b gaps %0d expected 3 010 0",
                                    r, bus.state, trig_now(), bad);
            end
        end
        for (int i = 0; i < ACK; i++) tick();
        bus.is_turning = 1'b1;
        tick();
        n_checks++;
        if ({bus.state, trig_now(), bus.busy} !== {3'd5, 3'b000, 1'b1}) begin
            n_fail++; $display("FAIL ack_on_timeout_cycle: got state %0d trig %b busy %b expected 5 000 1",
                                bus.state, trig_now(), bus.busy);
        end
        bus.is_turning = 1'b0;
        tick();
        model_count = (model_count + 1) % 256;
        n_checks++;
        if ({bus.state, bus.turn_count} !== {3'd6, 8'(model_count)}) begin
            n_fail++; $display("FAIL retry_turn_done: got state %0d count %0d expected 6 %0d",
                                bus.state, bus.turn_count, model_count);
        end
        wait_state(3'd1, EXT + 5, n);
    endtask

    task automatic test_full_turn();
        int bad;
        int n;
        bus.detector_left = 1'b0;
        bus.detector_front = 1'b1;
        wait_state(3'd3, DEB + SET + 10, n);
        tick();
        bus.is_turning = 1'b1;
        tick();
        bad = 0;
        for (int i = 0; i < 374; i++) begin
            tick();
            if ({bus.state, bus.busy, bus.move_forward} !== {3'd5, 1'b1, 1'b0}) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL wait_done_hold: got %0d bad cycles expected 0", bad);
        end
        bus.is_turning = 1'b0;
        tick();
        model_count = (model_count + 1) % 256;
        n_checks++;
        if ({bus.state, bus.move_forward, bus.busy, bus.turn_count} !== {3'd6, 1'b1, 1'b0, 8'(model_count)}) begin
            n_fail++; $display("FAIL exit_entry: got state %0d mf %b busy %b count %0d expected 6 1 0 %0d",
                                bus.state, bus.move_forward, bus.busy, bus.turn_count, model_count);
        end
        bad = 0;
        for (int i = 0; i < EXT - 1; i++) begin
            tick();
            if ({bus.state, bus.move_forward} !== {3'd6, 1'b1}) bad++;
        end
        tick();
        n_checks++;
        if ({bus.state, bus.move_forward} !== {3'd1, 1'b1} || bad != 0) begin
            n_fail++; $display("FAIL exit_length: got state %0d bad %0d expected 1 0", bus.state, bad);
        end
        bad = 0;
        for (int i = 0; i < DEB - 1; i++) begin
            tick();
            if (bus.state !== 3'd1) bad++;
        end
        tick();
        n_checks++;
        if (bus.state !== 3'd2 || bad != 0) begin
            n_fail++; $display("FAIL fresh_debounce: got state %0d early %0d expected 2 0", bus.state, bad);
        end
    endtask

    task automatic test_reset_in_settle();
        int bad;
        tick();
        rst_n = 1'b0;
        tick();
        model_count = 0;
        n_checks++;
        if ({bus.state, bus.move_forward, trig_now(), bus.busy, bus.turn_count} !== 14'd0) begin
            n_fail++; $display("FAIL reset_in_settle: got state %0d outs %b count %0d expected 0 00000 0",
                                bus.state, {bus.move_forward, trig_now(), bus.busy}, bus.turn_count);
        end
        bus.detector_front = 1'b0;
        tick();
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < SET + 10; i++) begin
            tick();
            if (trig_now() !== 3'b000) bad++;
        end
        n_checks++;
        if (bus.state !== 3'd1 || bad != 0) begin
            n_fail++; $display("FAIL no_trigger_after_reset: got state %0d triggers %0d expected 1 0",
                                bus.state, bad);
        end
    endtask

    task automatic test_enable_abort();
        int n;
        bus.detector_left = 1'($urandom_range(0, 1));
        bus.detector_right = 1'($urandom_range(0, 1));
        bus.detector_front = 1'b1;
        wait_state(3'd3, DEB + SET + 10, n);
        bus.detector_front = 1'b0;
        tick();
        bus.is_turning = 1'b1;
        tick();
        tick();
        tick();
        n_checks++;
        if (bus.state !== 3'd5) begin
            n_fail++; $display("FAIL abort_setup: got state %0d expected 5", bus.state);
        end
        bus.enable = 1'b0;
        tick();
        n_checks++;
        if ({bus.state, bus.move_forward, trig_now(), bus.busy, bus.turn_count} !==
            {3'd0, 5'b0, 8'(model_count)}) begin
            n_fail++; $display("FAIL enable_abort: got state %0d outs %b count %0d expected 0 00000 %0d",
                                bus.state, {bus.move_forward, trig_now(), bus.busy}, bus.turn_count, model_count);
        end
        bus.is_turning = 1'b0;
        bus.enable = 1'b1;
        tick();
        n_checks++;
        if ({bus.state, bus.turn_count} !== {3'd1, 8'(model_count)}) begin
            n_fail++; $display("FAIL reenable: got state %0d count %0d expected 1 %0d",
                                bus.state, bus.turn_count, model_count);
        end
    endtask

    task automatic test_random_turns();
        for (int it = 0; it < 12; it++) begin
            int g, w, hold, fires, bad, n, k;
            logic l, r;
            g = $urandom_range(1, DEB - 1);
            w = $urandom_range(0, 30);
            hold = $urandom_range(0, 20);
            l = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            bus.detector_left = l;
            bus.detector_right = r;
            bus.detector_front = 1'b1;
            bad = 0;
            for (int i = 0; i < g; i++) begin
                tick();
                if (bus.state !== 3'd1) bad++;
            end
            bus.detector_front = 1'b0;
            tick();
            if (bus.state !== 3'd1) bad++;
            bus.detector_front = 1'b1;
            wait_state(3'd3, DEB + SET + 10, n);
            bus.detector_front = 1'b0;
            n_checks++;
            if (n != DEB + SET || bad != 0 || trig_now() !== exp_trig(l, r)) begin
                n_fail++; $display("FAIL rand_fire_%0d: got latency %0d glitch %0d trig %b expected %0d 0 %b",
                                    it, n, bad, trig_now(), DEB + SET, exp_trig(l, r));
            end
            fires = 0;
            bad = 0;
            for (int t = 1; t <= w; t++) begin
                tick();
                if (trig_now() !== 3'b000) begin
                    fires++;
                    if (trig_now() !== exp_trig(l, r)) bad++;
                end
            end
            n_checks++;
            if (fires != w / (ACK + 1) || bad != 0) begin
                n_fail++; $display("FAIL rand_refires_%0d: got %0d wrong %0d expected %0d 0",
                                    it, fires, bad, w / (ACK + 1));
            end
            k = (w % (ACK + 1) == 0) ? 2 : 1;
            bus.is_turning = 1'b1;
            wait_state(3'd5, 4, n);
            n_checks++;
            if (n != k) begin
                n_fail++; $display("FAIL rand_ack_%0d: got %0d ticks expected %0d", it, n, k);
            end
            for (int i = 0; i < hold; i++) tick();
            bus.is_turning = 1'b0;
            tick();
            model_count = (model_count + 1) % 256;
            n_checks++;
            if ({bus.state, bus.turn_count} !== {3'd6, 8'(model_count)}) begin
                n_fail++; $display("FAIL rand_done_%0d: got state %0d count %0d expected 6 %0d",
                                    it, bus.state, bus.turn_count, model_count);
            end
            wait_state(3'd1, EXT + 5, n);
            n_checks++;
            if (n != EXT) begin
                n_fail++; $display("FAIL rand_exit_%0d: got %0d expected %0d", it, n, EXT);
            end
        end
    endtask

    task automatic test_wrap();
        int start, bad, n;
        start = model_count;
        bad = 0;
        for (int t = 0; t < 256; t++) begin
            bus.detector_left = 1'($urandom_range(0, 1));
            bus.detector_front = 1'b1;
            wait_state(3'd3, DEB + SET + 10, n);
            if (n < 0) bad++;
            bus.detector_front = 1'b0;
            finish_turn(n);
            if (n != EXT || bus.turn_count !== 8'(model_count)) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL wrap_sequence: got %0d bad turns expected 0", bad);
        end
        n_checks++;
        if (bus.turn_count !== 8'(start)) begin
            n_fail++; $display("FAIL wrap_value: got %0d expected %0d", bus.turn_count, start);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_debounce();
        test_directions();
        test_ack_retry();
        test_full_turn();
        test_reset_in_settle();
        test_enable_abort();
        test_random_turns();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
